// File: rtl/regfile_ctx_engine.sv
// Context save/restore engine for the 16 x 16-bit register file.
// Save streams a register range out of the spare read port; restore writes an
// incoming word stream back through the write port and flags framing errors.
module regfile_ctx_engine #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        save_req,
   input  logic        restore_req,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [3:0]  rf_addr_d,
   input  logic [15:0] rf_data_d,
   output logic        rf_w_en,
   output logic [3:0]  rf_addr_c,
   output logic [15:0] rf_data_c,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_last,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        in_last
);

   localparam logic [3:0] FIRST_IDX = 4'(FIRST_REG);
   localparam logic [3:0] LAST_IDX  = 4'(LAST_REG);

   typedef enum logic [2:0] {
      IDLE,
      SAVE_RD,
      SAVE_TX,
      RES_RX,
      RES_WR,
      FINISH
   } state_e;

   state_e      state_q;
   logic [3:0]  idx_q;
   logic        fe_q;
   logic        err_q;
   logic        w_en_q;
   logic [3:0]  addr_c_q;
   logic [15:0] data_c_q;
   logic        out_valid_q;
   logic [15:0] out_data_q;
   logic        out_last_q;
   logic        idx_last;
   logic [3:0]  idx_inc_d;

   assign idx_last  = (idx_q == LAST_IDX);
   // LAST_REG always terminates before the increment, so idx never wraps.
   assign idx_inc_d = idx_q + 4'd1;

   // Control FSM: sequences reads, stream handshakes and write-back pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= FIRST_IDX;
         fe_q        <= 1'b0;
         err_q       <= 1'b0;
         w_en_q      <= 1'b0;
         addr_c_q    <= 4'd0;
         data_c_q    <= 16'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 16'd0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Save has priority when both requests arrive together.
               if (save_req) begin
                  idx_q   <= FIRST_IDX;
                  state_q <= SAVE_RD;
               end else if (restore_req) begin
                  idx_q   <= FIRST_IDX;
                  state_q <= RES_RX;
               end
            end
            SAVE_RD: begin
               out_data_q  <= rf_data_d;
               out_last_q  <= idx_last;
               out_valid_q <= 1'b1;
               state_q     <= SAVE_TX;
            end
            SAVE_TX: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (idx_last) begin
                     state_q <= FINISH;
                  end else begin
                     idx_q   <= idx_inc_d;
                     state_q <= SAVE_RD;
                  end
               end
            end
            RES_RX: begin
               if (in_valid) begin
                  addr_c_q <= idx_q;
                  data_c_q <= in_data;
                  w_en_q   <= 1'b1;
                  // Sender's last marker must coincide with the last register.
                  fe_q     <= (in_last != idx_last);
                  state_q  <= RES_WR;
               end
            end
            RES_WR: begin
               w_en_q <= 1'b0;
               if (fe_q || idx_last) begin
                  err_q   <= fe_q;
                  state_q <= FINISH;
               end else begin
                  idx_q   <= idx_inc_d;
                  state_q <= RES_RX;
               end
            end
            FINISH: begin
               err_q   <= 1'b0;
               fe_q    <= 1'b0;
               idx_q   <= FIRST_IDX;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FINISH);
   assign err       = err_q;
   assign in_ready  = (state_q == RES_RX);
   assign rf_addr_d = (state_q == SAVE_RD) ? idx_q : 4'd0;
   assign rf_w_en   = w_en_q;
   assign rf_addr_c = addr_c_q;
   assign rf_data_c = data_c_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Directed bench for regfile_ctx_engine with a behavioural 16 x 16 register file.
module tb_regfile_ctx_engine;

   logic        clk;
   logic        rst;
   logic        save_req;
   logic        restore_req;
   logic        busy;
   logic        done;
   logic        err;
   logic [3:0]  rf_addr_d;
   logic [15:0] rf_data_d;
   logic        rf_w_en;
   logic [3:0]  rf_addr_c;
   logic [15:0] rf_data_c;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_last;

   int errors = 0;
   int checks = 0;

   logic [15:0] rf [16];
   logic        pre_en;
   logic [15:0] pre_base;
   int          wr_count = 0;

   regfile_ctx_engine #(.FIRST_REG(0), .LAST_REG(15)) dut (
      .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
      .busy(busy), .done(done), .err(err),
      .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
      .rf_w_en(rf_w_en), .rf_addr_c(rf_addr_c), .rf_data_c(rf_data_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: combinational read, write on rising edge, bulk preload.
   assign rf_data_d = rf[rf_addr_d];
   always @(posedge clk) begin
      if (pre_en) begin
         for (int i = 0; i < 16; i++) rf[i] <= pre_base + 16'(i);
      end else if (rf_w_en) begin
         rf[rf_addr_c] <= rf_data_c;
         wr_count      <= wr_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_busy"},      busy,      0);
      chk({pfx, "_done"},      done,      0);
      chk({pfx, "_err"},       err,       0);
      chk({pfx, "_rf_w_en"},   rf_w_en,   0);
      chk({pfx, "_rf_addr_c"}, rf_addr_c, 0);
      chk({pfx, "_rf_data_c"}, rf_data_c, 0);
      chk({pfx, "_rf_addr_d"}, rf_addr_d, 0);
      chk({pfx, "_out_valid"}, out_valid, 0);
      chk({pfx, "_out_data"},  out_data,  0);
      chk({pfx, "_out_last"},  out_last,  0);
      chk({pfx, "_in_ready"},  in_ready,  0);
   endtask

   task automatic preload(input logic [15:0] base);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_base = base;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   // mode 0: out_ready always high; mode 1: high one cycle in three.
   task automatic run_save(input int mode, input bit both, input logic [15:0] base);
      int          nw    = 0;
      int          dn    = 0;
      int          irdy  = 0;
      int          wr0   = wr_count;
      bit          stall = 0;
      logic [15:0] pd    = 16'd0;
      logic        pl    = 1'b0;
      @(negedge clk);
      save_req    = 1'b1;
      restore_req = both;
      @(negedge clk);
      save_req    = 1'b0;
      restore_req = 1'b0;
      for (int c = 0; c < 150; c++) begin
         out_ready   = (mode == 0) ? 1'b1 : (c % 3 == 0);
         restore_req = (c == 10);
         if (in_ready) irdy++;
         if (done) dn++;
         if (stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data",  out_data,  pd);
            chk("stall_last",  out_last,  pl);
         end
         if (out_valid && out_ready) begin
            chk("save_word", out_data, 32'(base) + 32'(nw));
            chk("save_last", out_last, (nw == 15));
            nw++;
         end
         stall = out_valid && !out_ready;
         pd    = out_data;
         pl    = out_last;
         @(negedge clk);
      end
      restore_req = 1'b0;
      out_ready   = 1'b0;
      chk("save_nwords",    nw, 16);
      chk("save_done_cnt",  dn, 1);
      chk("save_in_ready",  irdy, 0);
      chk("save_no_writes", wr_count - wr0, 0);
      chk("save_rf3",       rf[3], 32'(base) + 32'd3);
      chk("save_idle",      busy, 0);
   endtask

   // Streams 16'hA000+k with in_last on word last_at; registers start at pre+i.
   task automatic run_restore(input int last_at, input logic [15:0] pre, input bit exp_err);
      int   k   = 0;
      int   dn  = 0;
      logic ed  = 1'bx;
      int   wr0 = wr_count;
      @(negedge clk);
      restore_req = 1'b1;
      @(negedge clk);
      restore_req = 1'b0;
      for (int c = 0; c < 100; c++) begin
         in_valid = 1'b1;
         in_data  = 16'hA000 + 16'(k);
         in_last  = (k == last_at);
         if (done) begin
            dn++;
            ed = err;
         end
         if (in_ready) k++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("res_done_cnt", dn, 1);
      chk("res_err",      ed, exp_err);
      chk("res_wr_cnt",   wr_count - wr0, last_at + 1);
      chk("res_idle",     busy, 0);
      chk("res_err_clr",  err, 0);
      for (int i = 0; i < 16; i++)
         chk($sformatf("res_R%0d", i), rf[i],
             (i <= last_at) ? 32'hA000 + 32'(i) : 32'(pre) + 32'(i));
   endtask

   initial begin
      bit hit;
      int k;
      rst         = 1'b1;
      save_req    = 1'b0;
      restore_req = 1'b0;
      out_ready   = 1'b0;
      in_valid    = 1'b0;
      in_data     = 16'd0;
      in_last     = 1'b0;
      pre_en      = 1'b0;
      pre_base    = 16'd0;
      #3 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk_outputs_zero("reset");
      rst = 1'b1;
      @(negedge clk);
      chk("post_reset_busy", busy, 0);

      // Plain save, then save under backpressure.
      preload(16'h1000);
      run_save(0, 1'b0, 16'h1000);
      run_save(1, 1'b0, 16'h1000);

      // Simultaneous requests: save wins, in_ready stays low.
      run_save(0, 1'b1, 16'h1000);

      // Full restore and early-last restore.
      preload(16'h1000);
      run_restore(15, 16'h1000, 1'b0);
      preload(16'h1000);
      run_restore(4, 16'h1000, 1'b1);

      // Reset while the write of R7 is pending.
      preload(16'h1000);
      @(negedge clk);
      restore_req = 1'b1;
      @(negedge clk);
      restore_req = 1'b0;
      hit = 1'b0;
      k   = 0;
      for (int c = 0; c < 60 && !hit; c++) begin
         in_valid = 1'b1;
         in_data  = 16'hA000 + 16'(k);
         in_last  = (k == 15);
         if (rf_w_en && rf_addr_c == 4'd7) begin
            rst = 1'b0;
            #1;
            chk_outputs_zero("midreset");
            hit = 1'b1;
         end else begin
            if (in_ready) k++;
            @(negedge clk);
         end
      end
      chk("midreset_reached", hit, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_R7_kept",  rf[7], 16'h1007);
      chk("midreset_R6_wrote", rf[6], 16'hA006);
      chk("midreset_idle",     busy, 0);
      preload(16'h2000);
      run_save(0, 1'b0, 16'h2000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_ctx_engine.md
Name: regfile_ctx_engine

Overview:
- Context save/restore initiator for the 16 x 16-bit register file.
- Save: reads a register range through the file's spare read port (addr_d/data_d) and streams the words out on a valid/ready interface.
- Restore: accepts a valid/ready word stream and writes it back through the write port (addr_c/data_c/w_en).
- Sits between the register file and the debug/interrupt context-switch logic. Holds off the core's writeback while busy.

Parameters:
- FIRST_REG, 0, lowest register index in the range. Must satisfy FIRST_REG <= LAST_REG.
- LAST_REG, 15, highest register index in the range.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- save_req  input  1  start save; sampled in IDLE only.
- restore_req  input  1  start restore; sampled in IDLE only.
- busy  output  1  high whenever state != IDLE. The core gates its own w_en with this.
- done  output  1  one-cycle pulse at the end of an operation.
- err  output  1  restore framing error; valid while done=1.
- rf_addr_d  output  4  register file read-port address.
- rf_data_d  input  16  register file read data (combinational from rf_addr_d).
- rf_w_en  output  1  register file write enable.
- rf_addr_c  output  4  register file write address.
- rf_data_c  output  16  register file write data.
- out_valid  output  1  save stream valid.
- out_ready  input  1  save stream ready.
- out_data  output  16  save stream data.
- out_last  output  1  high with the final saved word.
- in_valid  input  1  restore stream valid.
- in_ready  output  1  restore stream ready.
- in_data  input  16  restore stream data.
- in_last  input  1  sender's marker for the final restore word.

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=FIRST_REG. All outputs 0: busy, done, err, rf_w_en, rf_addr_c, rf_data_c, rf_addr_d, out_valid, out_data, out_last, in_ready.
- Reset mid-operation aborts immediately. rf_w_en drops asynchronously, no partial write occurs, and no done pulse is issued.
- States: IDLE, SAVE_RD, SAVE_TX, RES_RX, RES_WR, FINISH.
- IDLE:
  - save_req -> SAVE_RD, with idx=FIRST_REG.
  - else restore_req -> RES_RX, with idx=FIRST_REG.
  - Both asserted together: save wins and restore_req is ignored.
  - Requests outside IDLE are ignored.
- SAVE_RD:
  - rf_addr_d=idx.
  - Edge: out_data<=rf_data_d, out_last<=(idx==LAST_REG), out_valid<=1; go to SAVE_TX.
- SAVE_TX:
  - out_valid, out_data and out_last are held stable until out_valid&out_ready.
  - On handshake: out_valid<=0, out_last<=0.
  - Then, if idx==LAST_REG -> FINISH; else idx<=idx+1 -> SAVE_RD.
  - Throughput is 2 cycles per word minimum.
- RES_RX:
  - in_ready=1 (combinational from state).
  - On in_valid&in_ready: rf_addr_c<=idx, rf_data_c<=in_data, rf_w_en<=1.
  - Record the framing error: fe<=(in_last != (idx==LAST_REG)). Go to RES_WR.
- RES_WR:
  - rf_w_en=1 for exactly this cycle; the register file captures the word on the edge leaving RES_WR.
  - rf_w_en<=0.
  - If fe or idx==LAST_REG -> FINISH, with err<=fe; else idx<=idx+1 -> RES_RX.
- Framing cases:
  - Early in_last: that word is written; the remaining registers are left untouched; err=1.
  - Final word without in_last: the word is written; err=1.
- FINISH: done=1 for one cycle, err held. Then -> IDLE, with err<=0 and idx<=FIRST_REG.
- Outside RES_WR, rf_w_en=0. rf_addr_c and rf_data_c hold their last values.
- busy=1 in every state except IDLE, including FINISH.
- idx is 4 bits and never wraps: LAST_REG terminates before any increment past 15.
- Latency (full 16-register range, no backpressure):
  - Save: save_req at edge 0; first out_valid after edge 2; done after edge 33.
  - Restore, in_valid held high: the first write commits at edge 3; done after edge 33.

Test Plan:
- Preload R[i]=16'h1000+i, out_ready=1, pulse save_req -> out_data 16'h1000..16'h100F in order. out_last only with 16'h100F; done pulses once; register file unchanged.
- Save with out_ready toggling 1 cycle on / 2 off -> same 16-word sequence. out_data/out_last are stable while out_valid&!out_ready, and no word is dropped or duplicated.
- Restore stream 16'hA000+i, in_last on the 16th word -> R[i]=16'hA000+i, exactly 16 rf_w_en pulses, err=0 with done.
- Restore with in_last on word 5 (idx=4) -> R0..R4 written, R5..R15 unchanged, done with err=1, then busy=0.
- save_req and restore_req asserted in the same IDLE cycle -> save runs and in_ready stays 0 throughout. restore_req during busy is ignored.
- rst=0 in RES_WR during restore of idx=7 -> rf_w_en=0 immediately, R7 keeps its old value, all outputs 0. After release the block is in IDLE and a new save works.
